// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode, funct and ALU-control encodings for the multi-cycle MIPS controller.
package mc_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEX,
        S_RTWB,
        S_BEQ,
        S_JMP,
`ifdef MC_CTRL_IMM_EN
        S_IMMEX,
        S_IMMWB,
`endif
        S_TRAP
    } state_t;
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps an R-type funct field to an ALU operation and flags unsupported functs.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal
);
    always_comb begin
        alu_op  = funct == FN_ADD ? ALU_ADD :
                  funct == FN_SUB ? ALU_SUB :
                  funct == FN_OR  ? ALU_OR  :
                  funct == FN_SLT ? ALU_SLT : ALU_AND;
        illegal = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM with a request/ready unified memory port.
// Define MC_CTRL_IMM_EN to add addi/andi/ori support via the IMMEX/IMMWB states.
module mc_controller
    import mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int STATE_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 illegal_op,
    output logic [STATE_W-1:0]   state_out
);
    state_t     state_q, state_d;
    logic       illegal_op_q, illegal_op_d;
    logic       pc_write, branch_state, fn_illegal;
    logic [2:0] alu_op, fn_op;

    mc_alu_decoder u_alu_dec (
        .funct   (funct),
        .alu_op  (fn_op),
        .illegal (fn_illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: case (opcode)
                OP_LW, OP_SW: state_d = S_MEMADR;
                OP_RTYPE:     state_d = S_RTEX;
                OP_BEQ:       state_d = S_BEQ;
                OP_J:         state_d = S_JMP;
`ifdef MC_CTRL_IMM_EN
                OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
`endif
                default:      state_d = S_TRAP;
            endcase
            S_MEMADR: state_d = opcode == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   state_d = fn_illegal ? S_TRAP : S_RTWB;
`ifdef MC_CTRL_IMM_EN
            S_IMMEX:  state_d = S_IMMWB;
`endif
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        illegal_op_d = illegal_op_q | (state_d == S_TRAP);
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch_state = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = ALU_AND;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = fn_op;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_SUB;
                pc_src       = 2'b01;
                branch_state = 1'b1;
            end
            S_JMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MC_CTRL_IMM_EN
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_ADD;
            end
            S_IMMWB: reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign pc_en       = pc_write | (branch_state & zero);
    assign alu_control = ALUCTRL_W'(alu_op);
    assign illegal_op  = illegal_op_q;
    assign state_out   = STATE_W'(state_q);
endmodule
